bcd_convert_sched: RTL and testbench
====================================

Name: bcd_convert_sched

Overview:
- Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between two requesters on the stopwatch display path: running time and lap/split value.
- Round-robin arbitration.
- Accepts 14-bit binary values and produces four BCD digits with a valid/ready output handshake.
- Sits between the stopwatch counters and the 7-segment digit scanner.

Parameters:
- WIDTH, 14, binary input width; fixed at 14 for a 4-digit display.
- NDIG, 4, number of BCD output digits.
- MAX_VAL, 9999, saturation ceiling applied to input values.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester level request; req[i] is held high until ack[i].
- val0  in  14  binary value of requester 0; stable while req[0] is high.
- val1  in  14  binary value of requester 1; stable while req[1] is high.
- ack  out  2  one-cycle pulse; value sampled in that cycle.
- busy  out  1  high in SHIFT and DONE.
- out_valid  out  1  digits valid; held until accepted.
- out_ready  in  1  consumer accepts digits when out_valid and out_ready are both high.
- out_src  out  1  requester index of the current result.
- out_sat  out  1  input exceeded MAX_VAL and was clamped.
- d3, d2, d1, d0  out  4 each  BCD digits, thousands down to units.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, shift register=0.
  - Outputs: ack=00, busy=0, out_valid=0, out_src=0, out_sat=0, d3..d0=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is set, grant per round-robin: if both are set, grant the index != last_grant; otherwise grant the single requester.
  - In the same cycle: ack[g]=1, load value (clamped to MAX_VAL, out_sat recorded), counter=14, out_src=g, last_grant=g, go to SHIFT.
  - ack is combinational from state and req. Exactly one ack bit per accept.
- SHIFT:
  - Each cycle, every BCD nibble >=5 gets +3, then the {bcd, bin} register shifts left 1 and counter decrements.
  - After the 14th shift, latch digits and go to DONE.
  - req is ignored during SHIFT.
- DONE: out_valid=1 and digits held stable. On out_ready, clear out_valid and go to IDLE.
- Timing:
  - Accept at cycle T; out_valid is first high at T+15.
  - Minimum spacing between accepts is 16 cycles, because IDLE lasts at least one cycle after DONE.
  - out_ready in the same cycle the DONE state is entered counts: the handshake completes on that edge.
- Simultaneous events:
  - A req arriving while in DONE with out_ready high is not accepted until the next cycle in IDLE.
  - A requester dropping req before its ack is legal and simply not served.
- Arithmetic:
  - 30-bit working register (16 BCD + 14 binary).
  - After clamping, no digit can exceed 9.
  - Inputs 10000..16383 output 9,9,9,9 with out_sat=1.
- Reset mid-operation: the in-flight conversion is lost and not re-acked. The requester must re-request.
- out_valid never drops without a handshake. Digits, out_src and out_sat are stable while out_valid=1.

Optional Feature:
- Macro BCD_SCHED_BLANK_LEADING_EN.
- When defined: leading zero digits (from d3 downward, stopping before d0) are replaced by 4'hF, the blank code the scanner renders as dark. Applied when digits are latched. d0 is never blanked.
- When undefined: plain BCD, zeros shown.

Decomposition:
- Shared package bcd_pkg holds:
  - state typedef {IDLE, SHIFT, DONE}
  - BCD_BLANK=4'hF
  - MAX_VAL, WIDTH, NDIG constants
- One natural sub-module, bcd_dabble_step: combinational add-3-per-nibble plus 1-bit left shift of the 30-bit register, instantiated once in SHIFT.

Test Plan:
- req=01, val0=1234, out_ready=1 -> ack=01 at T, out_valid at T+15 with d3..d0=1,2,3,4, out_src=0, out_sat=0.
- req=10, val1=12000 -> digits 9,9,9,9, out_sat=1, out_src=1; val1=9999 -> 9,9,9,9, out_sat=0; val1=0 -> 0,0,0,0.
- req=11 held continuously, val0=5, val1=7, out_ready=1 -> results alternate src 0,1,0,1 with values 5,7,5,7; accepts are 16 cycles apart.
- out_ready=0 for 20 cycles after out_valid -> digits and out_valid are stable, busy=1, no ack to a pending req; raising out_ready yields the next accept one cycle later.
- Assert rst_n=0 at T+7 of a conversion -> all outputs reset immediately with no out_valid; after release with req still high, a fresh ack and a correct result at +15.
- With BCD_SCHED_BLANK_LEADING_EN: 42 -> F,F,4,2; 0 -> F,F,F,0; 1005 -> 1,0,0,5.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the stopwatch binary-to-BCD scheduler.
// Optional leading-zero blanking helper used when BCD_SCHED_BLANK_LEADING_EN is defined.
package bcd_pkg;

  localparam int unsigned WIDTH   = 14;
  localparam int unsigned NDIG    = 4;
  localparam int unsigned MAX_VAL = 9999;
  localparam int unsigned BCD_W   = NDIG * 4;
  localparam int unsigned REG_W   = BCD_W + WIDTH;
  localparam int unsigned CNT_W   = 4;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Replace leading zero digits with the blank code; the units digit always shows.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
        res[i*4 +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_convert_sched_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the {bcd, bin} working register left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [REG_W-1:0] reg_i,
  output logic [REG_W-1:0] reg_o
);

  logic [REG_W-1:0] adj;

  always_comb begin
    adj = reg_i;
    for (int n = 0; n < NDIG; n++) begin
      if (reg_i[WIDTH + 4*n +: 4] >= 4'd5) begin
        adj[WIDTH + 4*n +: 4] = reg_i[WIDTH + 4*n +: 4] + 4'd3;
      end
    end
    reg_o = adj << 1;
  end

endmodule

// File: rtl/bcd_convert_sched.sv
// Round-robin shared binary-to-BCD converter for running time and lap value.
// Define BCD_SCHED_BLANK_LEADING_EN to blank leading zero digits (d3..d1) with 4'hF.
module bcd_convert_sched
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic             out_sat,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               last_grant_q, last_grant_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               out_src_q, out_src_d;
  logic               out_sat_q, out_sat_d;

  logic               grant;
  logic [WIDTH-1:0]   sel_val;
  logic               over;
  logic [WIDTH-1:0]   clamped;
  logic [REG_W-1:0]   step_out;
  logic [BCD_W-1:0]   final_bcd;

  bcd_dabble_step u_step (
    .reg_i (work_q),
    .reg_o (step_out)
  );

  // Digits after the last shift, optionally with leading zeros blanked.
  always_comb begin
`ifdef BCD_SCHED_BLANK_LEADING_EN
    final_bcd = blank_leading(step_out[REG_W-1 -: BCD_W]);
`else
    final_bcd = step_out[REG_W-1 -: BCD_W];
`endif
  end

  // Arbitration and input clamp, evaluated every cycle but used only in IDLE.
  always_comb begin
    grant   = (req == 2'b11) ? ~last_grant_q : req[1];
    sel_val = grant ? val1 : val0;
    over    = (sel_val > WIDTH'(MAX_VAL));
    clamped = over ? WIDTH'(MAX_VAL) : sel_val;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    dig_d        = dig_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    out_sat_d    = out_sat_q;
    ack          = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (rst_n && (req != 2'b00)) begin
          ack          = grant ? 2'b10 : 2'b01;
          work_d       = {BCD_W'(0), clamped};
          cnt_d        = CNT_W'(WIDTH);
          out_src_d    = grant;
          out_sat_d    = over;
          last_grant_d = grant;
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          dig_d       = final_bcd;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_q       <= '0;
      dig_q        <= '0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_src_q    <= 1'b0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      dig_q        <= dig_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_sat   = out_sat_q;
  assign d3        = dig_q[15:12];
  assign d2        = dig_q[11:8];
  assign d1        = dig_q[7:4];
  assign d0        = dig_q[3:0];

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Self-checking bench for bcd_convert_sched: randomized requests against a
// decimal-arithmetic reference model with round-robin grant tracking.
module tb_bcd_convert_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [13:0] val0, val1;
  logic [1:0]  ack;
  logic        busy, out_valid, out_ready, out_src, out_sat;
  logic [3:0]  d3, d2, d1, d0;
  logic [15:0] dig;

  int checks = 0;
  int errors = 0;
  logic lg;  // model of the last granted requester

  assign dig = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  bcd_convert_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .val0      (val0),
    .val1      (val1),
    .ack       (ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_sat   (out_sat),
    .d3        (d3),
    .d2        (d2),
    .d1        (d1),
    .d0        (d0)
  );

  // Expected display digits: decimal digits of min(v, 9999), optionally blanked.
  function automatic logic [15:0] exp_dig(input int unsigned v);
    int unsigned c, p;
    int          nd;
    logic [15:0] r;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'((c / p) % 10);
      p = p * 10;
    end
`ifdef BCD_SCHED_BLANK_LEADING_EN
    nd = (c >= 1000) ? 4 : (c >= 100) ? 3 : (c >= 10) ? 2 : 1;
    for (int k = nd; k < 4; k++) r[k*4 +: 4] = 4'hF;
`else
    nd = 0;
`endif
    return r;
  endfunction

  function automatic logic exp_grant(input logic [1:0] r, input logic last);
    return (r == 2'b11) ? ~last : r[1];
  endfunction

  // Issue one request, drop it after its ack, and collect the result.
  task automatic run_conv(input logic [1:0] r, input logic [13:0] v0, input logic [13:0] v1,
                          output int lat, output logic [1:0] ackv, output logic [15:0] dv,
                          output logic src, output logic sat);
    int n;
    @(negedge clk);
    req = r; val0 = v0; val1 = v1; out_ready = 1'b1;
    #1;
    n = 0;
    while (ack == 2'b00 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    ackv = ack;
    lat = -1; dv = 16'h0; src = 1'b0; sat = 1'b0;
    if (ackv != 2'b00) begin
      @(negedge clk); #1;
      req = 2'b00;
      lat = 1;
      while (!out_valid && lat < 40) begin
        @(negedge clk); #1; lat++;
      end
      dv = dig; src = out_src; sat = out_sat;
    end
    req = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; val0 = '0; val1 = '0; out_ready = 1'b1;
    lg = 1'b1;
    #12;
    checks++;
    if ({ack, busy, out_valid, out_src, out_sat, dig} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b busy=%b ov=%b src=%b sat=%b dig=%h, need all zero",
               ack, busy, out_valid, out_src, out_sat, dig);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({ack, busy, out_valid} !== 4'h0) begin
      errors++;
      $display("FAIL reset_release: got ack=%b busy=%b ov=%b, need 0", ack, busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat; logic [1:0] a; logic [15:0] dv; logic s, t;
    run_conv(2'b01, 14'd1234, 14'd0, lat, a, dv, s, t);
    checks++; if (a !== 2'b01) begin errors++; $display("FAIL basic_ack: got %b need 01", a); end
    checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency: got %0d need 15", lat); end
    checks++; if (dv !== exp_dig(1234)) begin errors++; $display("FAIL basic_digits: got %h need %h", dv, exp_dig(1234)); end
    checks++; if ({s, t} !== 2'b00) begin errors++; $display("FAIL basic_src_sat: got %b%b need 00", s, t); end
    lg = 1'b0;
  endtask

  task automatic test_saturate();
    int unsigned tbl [6] = '{12000, 9999, 0, 10000, 16383, 9998};
    int lat; logic [1:0] a; logic [15:0] dv; logic s, t;
    for (int i = 0; i < 6; i++) begin
      run_conv(2'b10, 14'd0, 14'(tbl[i]), lat, a, dv, s, t);
      checks++;
      if (a !== 2'b10 || lat != 15 || s !== 1'b1) begin
        errors++;
        $display("FAIL sat_handshake v=%0d: got ack=%b lat=%0d src=%b need 10/15/1", tbl[i], a, lat, s);
      end
      checks++;
      if (dv !== exp_dig(tbl[i]) || t !== (tbl[i] > 9999)) begin
        errors++;
        $display("FAIL sat_value v=%0d: got dig=%h sat=%b need %h/%b", tbl[i], dv, t,
                 exp_dig(tbl[i]), (tbl[i] > 9999));
      end
      lg = 1'b1;
    end
  endtask

  task automatic test_random();
    int lat; logic [1:0] a, r, ea; logic [15:0] dv; logic s, t, g;
    int unsigned v0, v1, ev;
    for (int i = 0; i < 30; i++) begin
      r  = 2'($urandom_range(1, 3));
      v0 = $urandom_range(0, 16383);
      v1 = (i % 4 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
      g  = exp_grant(r, lg);
      ea = g ? 2'b10 : 2'b01;
      ev = g ? v1 : v0;
      run_conv(r, 14'(v0), 14'(v1), lat, a, dv, s, t);
      checks++;
      if (a !== ea || s !== g || lat != 15) begin
        errors++;
        $display("FAIL rand_grant #%0d req=%b: got ack=%b src=%b lat=%0d need %b/%b/15", i, r, a, s, lat, ea, g);
      end
      checks++;
      if (dv !== exp_dig(ev) || t !== (ev > 9999)) begin
        errors++;
        $display("FAIL rand_value #%0d v=%0d: got %h sat=%b need %h sat=%b", i, ev, dv, t, exp_dig(ev), (ev > 9999));
      end
      lg = g;
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [4]; logic [1:0] acc_v [4]; logic res_src [4]; logic [15:0] res_d [4];
    int na, nr, cyc;
    logic g;
    na = 0; nr = 0; cyc = 0;
    @(negedge clk);
    req = 2'b11; val0 = 14'd5; val1 = 14'd7; out_ready = 1'b1;
    #1;
    while (nr < 4 && cyc < 120) begin
      if (ack != 2'b00 && na < 4) begin acc_cyc[na] = cyc; acc_v[na] = ack; na++; end
      if (out_valid) begin res_src[nr] = out_src; res_d[nr] = dig; nr++; end
      if (nr < 4) begin @(negedge clk); #1; cyc++; end
    end
    req = 2'b00;
    checks++;
    if (nr != 4 || na != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d accepts %0d results, need 4/4", na, nr);
    end else begin
      for (int k = 0; k < 4; k++) begin
        g = (k % 2 == 0) ? ~lg : lg;
        checks++;
        if (acc_v[k] !== (g ? 2'b10 : 2'b01) || res_src[k] !== g || res_d[k] !== exp_dig(g ? 7 : 5)) begin
          errors++;
          $display("FAIL rr_result #%0d: got ack=%b src=%b dig=%h need src=%b dig=%h", k, acc_v[k],
                   res_src[k], res_d[k], g, exp_dig(g ? 7 : 5));
        end
        if (k > 0) begin
          checks++;
          if (acc_cyc[k] - acc_cyc[k-1] != 16) begin
            errors++;
            $display("FAIL rr_spacing #%0d: got %0d need 16", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
      lg = ~lg;
    end
  endtask

  task automatic test_stall();
    int unsigned v, w;
    int n;
    logic [15:0] held;
    v = $urandom_range(0, 9999);
    w = $urandom_range(0, 16383);
    @(negedge clk);
    out_ready = 1'b0; req = 2'b01; val0 = 14'(v); #1;
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL stall_ack0: got %b need 01", ack); end
    @(negedge clk); #1;
    req = 2'b10; val1 = 14'(w);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); #1; n++; end
    held = dig;
    checks++;
    if (held !== exp_dig(v)) begin errors++; $display("FAIL stall_digits: got %h need %h", held, exp_dig(v)); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || ack !== 2'b00 || dig !== held || out_src !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d: got ov=%b busy=%b ack=%b dig=%h src=%b", i, out_valid, busy, ack, dig, out_src);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1; #1;
    checks++;
    if (ack !== 2'b00) begin errors++; $display("FAIL stall_early_ack: got %b need 00", ack); end
    @(negedge clk); #1;
    checks++;
    if (ack !== 2'b10 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_next_ack: got ack=%b ov=%b need 10/0", ack, out_valid);
    end
    @(negedge clk); #1;
    req = 2'b00;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (n != 15 || dig !== exp_dig(w) || out_src !== 1'b1 || out_sat !== (w > 9999)) begin
      errors++;
      $display("FAIL stall_second: got lat=%0d dig=%h src=%b sat=%b need 15/%h/1/%b", n, dig, out_src, out_sat,
               exp_dig(w), (w > 9999));
    end
    lg = 1'b1;
  endtask

  task automatic test_reset_mid();
    int unsigned v;
    int n;
    v = $urandom_range(0, 9999);
    @(negedge clk);
    req = 2'b01; val0 = 14'(v); out_ready = 1'b1; #1;
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL rstmid_ack: got %b need 01", ack); end
    for (int i = 0; i < 7; i++) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if ({ack, busy, out_valid, out_src, out_sat, dig} !== 22'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ack=%b busy=%b ov=%b src=%b sat=%b dig=%h, need zero",
               ack, busy, out_valid, out_src, out_sat, dig);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; lg = 1'b1; #1;
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL rstmid_reack: got %b need 01", ack); end
    @(negedge clk); #1;
    req = 2'b00;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (n != 15 || dig !== exp_dig(v) || out_src !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_result: got lat=%0d dig=%h src=%b need 15/%h/0", n, dig, out_src, exp_dig(v));
    end
    lg = 1'b0;
  endtask

  task automatic test_blank();
    int unsigned tbl [6] = '{42, 0, 1005, 7, 100, 9090};
    int lat; logic [1:0] a; logic [15:0] dv; logic s, t;
    for (int i = 0; i < 6; i++) begin
      run_conv(2'b01, 14'(tbl[i]), 14'd0, lat, a, dv, s, t);
      checks++;
      if (dv !== exp_dig(tbl[i]) || lat != 15) begin
        errors++;
        $display("FAIL blank_value v=%0d: got %h lat=%0d need %h/15", tbl[i], dv, lat, exp_dig(tbl[i]));
      end
      lg = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_blank();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
